// File: rtl/pipe_adder_tree.sv
// Pipelined adder tree: NUM_IN operands are summed pairwise over clog2(NUM_IN) registered
// levels behind an operand register; one global advance stalls the whole pipe together.
module pipe_adder_tree #(
    parameter int IN_W   = 10,
    parameter int NUM_IN = 4,
    parameter int SIGNED = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_IN*IN_W-1:0]             in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [IN_W+$clog2(NUM_IN)-1:0]     out_data,
    output logic                               busy
);
    localparam int LVL   = $clog2(NUM_IN);
    localparam int OUT_W = IN_W + LVL;
    localparam int LAT   = LVL + 1;

    // Every level is packed into one flat vector; level l holds cnt_at(l) nodes of IN_W+l bits.
    function automatic int cnt_at(input int lvl);
        return (NUM_IN + (1 << lvl) - 1) >> lvl;
    endfunction

    function automatic int off_at(input int lvl);
        int off;
        off = 0;
        for (int j = 0; j < lvl; j++) off += cnt_at(j) * (IN_W + j);
        return off;
    endfunction

    localparam int TOT_W = off_at(LVL) + OUT_W;

    logic [TOT_W-1:0] data_q;
    logic [TOT_W-1:0] data_d;
    logic [TOT_W-1:0] shift_val;
    logic [LAT-1:0]   valid_q;
    logic [LAT-1:0]   valid_d;
    logic             advance;

    assign out_valid = valid_q[LAT-1];
    assign out_data  = data_q[TOT_W-1 -: OUT_W];
    assign busy      = |valid_q;
    assign advance   = out_ready | ~out_valid;
    assign in_ready  = advance;

    assign shift_val[NUM_IN*IN_W-1:0] = in_data;

    for (genvar l = 1; l <= LVL; l = l + 1) begin : g_lvl
        localparam int PW   = IN_W + l - 1;
        localparam int PCNT = cnt_at(l - 1);
        localparam int POFF = off_at(l - 1);
        localparam int W    = IN_W + l;
        localparam int OFF  = off_at(l);

        for (genvar k = 0; k < cnt_at(l); k = k + 1) begin : g_node
            logic [PW-1:0] a_v;
            logic [W-1:0]  a_ext;

            assign a_v   = data_q[POFF + 2*k*PW +: PW];
            assign a_ext = {(SIGNED != 0) & a_v[PW-1], a_v};

            if (2*k + 1 < PCNT) begin : g_pair
                logic [PW-1:0] b_v;
                logic [W-1:0]  b_ext;

                assign b_v   = data_q[POFF + (2*k+1)*PW +: PW];
                assign b_ext = {(SIGNED != 0) & b_v[PW-1], b_v};
                assign shift_val[OFF + k*W +: W] = a_ext + b_ext;
            end else begin : g_pass
                // Odd node out rides along one level, only widened.
                assign shift_val[OFF + k*W +: W] = a_ext;
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (advance) begin
            data_d  = shift_val;
            valid_d = {valid_q[LAT-2:0], in_valid};
        end
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_pipe_adder_tree.sv
// Bench for pipe_adder_tree: directed scenarios plus randomized streaming, checked against
// a queue of expected sums computed directly from the operands.
module tb_pipe_adder_tree;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        busy;

    logic        s_flush;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [23:0] s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [9:0]  s_out_data;
    logic        s_busy;

    int          total;
    int          bad;
    logic [9:0]  cur_ops [4];
    int          exp_q [$];
    int          exp_pop;
    bit          accepted;
    bit          popped;
    logic        obs_valid;
    logic        obs_ready;
    logic        obs_busy;
    logic [11:0] obs_data;

    pipe_adder_tree dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    pipe_adder_tree #(.IN_W(8), .NUM_IN(3), .SIGNED(1)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (s_flush),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .busy      (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_beat(input int a, input int b, input int c, input int d);
        cur_ops[0] = a[9:0];
        cur_ops[1] = b[9:0];
        cur_ops[2] = c[9:0];
        cur_ops[3] = d[9:0];
        for (int k = 0; k < 4; k++) in_data[k*10 +: 10] = cur_ops[k];
    endtask

    task automatic set_random_beat();
        set_beat(int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)),
                 int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)));
    endtask

    function automatic int model_sum();
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += int'(cur_ops[k]);
        return s;
    endfunction

    // One clock of the default instance: sample mid-cycle, update the expected-result queue.
    task automatic tick();
        @(negedge clk);
        obs_valid = out_valid;
        obs_data  = out_data;
        obs_ready = in_ready;
        obs_busy  = busy;
        accepted  = 1'b0;
        popped    = 1'b0;
        if (obs_valid && out_ready) begin
            popped  = 1'b1;
            exp_pop = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        end
        if (flush) exp_q.delete();
        else if (in_valid && obs_ready) begin
            accepted = 1'b1;
            exp_q.push_back(model_sum());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;
        set_beat(0, 0, 0, 0);
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 12'd0) begin bad++; $display("[TB] FAIL reset_out_data: got %0d want 0", out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (s_out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_s_out_valid: got %b want 0", s_out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        set_beat(1, 2, 3, 4);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (!accepted) begin bad++; $display("[TB] FAIL single_accept: got %b want 1", obs_ready); end
        for (int c = 1; c <= 5; c++) begin
            tick();
            total++;
            if (obs_valid !== (c == 3)) begin
                bad++; $display("[TB] FAIL single_latency edge %0d: got out_valid=%b want %b", c, obs_valid, c == 3);
            end
            if (popped) begin
                total++;
                if (int'(obs_data) !== 10 || exp_pop !== 10) begin
                    bad++; $display("[TB] FAIL single_sum: got %0d want 10", obs_data);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int beats [3][4] = '{'{1, 2, 3, 0}, '{4, 5, 6, 0}, '{7, 8, 9, 0}};
        int want [3] = '{6, 15, 24};
        int pops = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c < 3) begin
                set_beat(beats[c][0], beats[c][1], beats[c][2], beats[c][3]);
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            tick();
            if (c < 3) begin
                total++; if (!accepted) begin bad++; $display("[TB] FAIL b2b_accept beat %0d: got 0 want 1", c); end
            end
            if (popped) begin
                total++;
                if (pops >= 3) begin
                    bad++; $display("[TB] FAIL b2b_extra: got %0d want no result", obs_data);
                end else if (int'(obs_data) !== want[pops] || c !== 3 + pops) begin
                    bad++; $display("[TB] FAIL b2b_result %0d: got %0d at cycle %0d want %0d at cycle %0d",
                                    pops, obs_data, c, want[pops], 3 + pops);
                end
                pops++;
            end
        end
        total++; if (pops !== 3) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 3", pops); end
    endtask

    task automatic test_max();
        bit got = 1'b0;
        out_ready = 1'b1;
        set_beat(1023, 1023, 1023, 1023);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            tick();
            if (popped) begin
                got = 1'b1;
                total++;
                if (obs_data !== 12'hFFC || exp_pop !== 4092) begin
                    bad++; $display("[TB] FAIL max_sum: got %0d want 4092", obs_data);
                end
            end
        end
        total++; if (!got) begin bad++; $display("[TB] FAIL max_timeout: got no result want 4092"); end
    endtask

    task automatic test_stall();
        int sent = 0;
        int stall = 0;
        int delivered = 0;
        bit first = 1'b0;
        set_random_beat();
        for (int c = 0; c < 40; c++) begin
            in_valid  = (sent < 10);
            out_ready = (stall == 0);
            tick();
            if (accepted) begin sent++; set_random_beat(); end
            if (stall > 0) begin
                total++;
                if (obs_ready !== 1'b0 || obs_valid !== 1'b1 ||
                    int'(obs_data) !== ((exp_q.size() > 0) ? exp_q[0] : -1)) begin
                    bad++; $display("[TB] FAIL stall_hold: got ready=%b valid=%b data=%0d want ready=0 valid=1 data=%0d",
                                    obs_ready, obs_valid, obs_data, (exp_q.size() > 0) ? exp_q[0] : -1);
                end
                stall--;
            end
            if (popped) begin
                total++;
                if (int'(obs_data) !== exp_pop) begin
                    bad++; $display("[TB] FAIL stall_order: got %0d want %0d", obs_data, exp_pop);
                end
                delivered++;
                if (!first) begin first = 1'b1; stall = 4; end
            end
        end
        in_valid = 1'b0;
        total++; if (delivered !== 10 || exp_q.size() !== 0) begin
            bad++; $display("[TB] FAIL stall_delivered: got %0d want 10", delivered);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 3);
            flush    = (c == 2);
            set_random_beat();
            tick();
            flush = 1'b0;
            if (c == 3) begin
                total++; if (obs_busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_busy: got %b want 0", obs_busy); end
            end
            if (c >= 2) begin
                total++; if (obs_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_no_result cycle %0d: got valid=1 want 0", c); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        bit got = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            set_random_beat();
            in_valid = 1'b1;
            tick();
            if (popped) begin
                total++;
                if (int'(obs_data) !== exp_pop) begin bad++; $display("[TB] FAIL midrst_stream: got %0d want %0d", obs_data, exp_pop); end
            end
        end
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL midrst_pre_valid: got %b want 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 12'd0 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL midrst_async: got valid=%b data=%0d busy=%b want 0 0 0", out_valid, out_data, busy);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_beat(5, 6, 7, 8);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (!accepted) begin bad++; $display("[TB] FAIL midrst_resume_accept: got 0 want 1"); end
        for (int c = 0; c < 6 && !got; c++) begin
            tick();
            if (popped) begin
                got = 1'b1;
                total++; if (int'(obs_data) !== 26) begin bad++; $display("[TB] FAIL midrst_resume_sum: got %0d want 26", obs_data); end
            end
        end
        total++; if (!got) begin bad++; $display("[TB] FAIL midrst_timeout: got no result want 26"); end
    endtask

    task automatic test_random();
        bit          prev_stall = 1'b0;
        logic [11:0] prev_data  = '0;
        set_random_beat();
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(3, 0) != 0);
            tick();
            total++;
            if (obs_ready !== (out_ready | ~obs_valid)) begin
                bad++; $display("[TB] FAIL rand_in_ready cycle %0d: got %b want %b", c, obs_ready, out_ready | ~obs_valid);
            end
            if (prev_stall) begin
                total++;
                if (obs_valid !== 1'b1 || obs_data !== prev_data) begin
                    bad++; $display("[TB] FAIL rand_stable cycle %0d: got valid=%b data=%0d want 1 %0d", c, obs_valid, obs_data, prev_data);
                end
            end
            if (popped) begin
                total++;
                if (int'(obs_data) !== exp_pop) begin bad++; $display("[TB] FAIL rand_result cycle %0d: got %0d want %0d", c, obs_data, exp_pop); end
            end
            if (accepted) set_random_beat();
            prev_stall = obs_valid && !out_ready;
            prev_data  = obs_data;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (popped) begin
                total++;
                if (int'(obs_data) !== exp_pop) begin bad++; $display("[TB] FAIL rand_drain: got %0d want %0d", obs_data, exp_pop); end
            end
        end
        total++; if (exp_q.size() !== 0) begin bad++; $display("[TB] FAIL rand_lost: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_signed();
        int ops [3];
        int want;
        bit got;
        s_out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            if (t == 0) ops = '{-1, -2, 5};
            else for (int k = 0; k < 3; k++) ops[k] = int'($urandom_range(255, 0)) - 128;
            want = ops[0] + ops[1] + ops[2];
            for (int k = 0; k < 3; k++) s_in_data[k*8 +: 8] = ops[k][7:0];
            s_in_valid = 1'b1;
            @(negedge clk);
            total++; if (s_in_ready !== 1'b1) begin bad++; $display("[TB] FAIL signed_accept: got %b want 1", s_in_ready); end
            @(posedge clk);
            #1;
            s_in_valid = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge clk);
                if (s_out_valid) begin
                    got = 1'b1;
                    total++;
                    if (int'($signed(s_out_data)) !== want || c !== 2) begin
                        bad++; $display("[TB] FAIL signed_sum: got %0d at edge %0d want %0d at edge 2",
                                        $signed(s_out_data), c, want);
                    end
                end
                @(posedge clk);
                #1;
            end
            total++; if (!got) begin bad++; $display("[TB] FAIL signed_timeout: got no result want %0d", want); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_max();
        test_stall();
        test_flush();
        test_mid_reset();
        test_random();
        test_signed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
